fx2_fifo_port: RTL and testbench
================================

# fx2_fifo_port

Synchronous FX2 slave-FIFO port controller that sits directly upstream and downstream of the QSPI bridge core. It owns all FX2 FIFO pins and turns EP2 OUT into a buffered ready/valid receive byte stream. It turns a ready/valid transmit byte stream into EP6 IN writes with explicit packet commit (PKTEND). It replaces the per-byte trigger handshakes with streaming interfaces, so the bridge core can consume and produce one byte at a time without knowing FX2 timing.

## Interface
- RX_DEPTH, 4: receive buffer entries; power of two, minimum 2.
- FX_IFCLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- FX_FIFOADR1  out  1  endpoint select; 0 = EP2 OUT, 1 = EP6 IN. FIFOADR0 is grounded on the board.
- FX_FULL  in  1  FLAGA, EP6 IN full, active low: 1 = space available.
- FX_EMPTY  in  1  FLAGB, EP2 OUT empty, active low: 1 = data available.
- FX_SLOE, FX_SLRD, FX_SLWR, FX_PKTEND  out  1 each  FX2 strobes, active low.
- FX_DATA  inout  8  FX2 data bus.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data is valid.
- rx_ready  in  1  consumer accepts the byte.
- tx_data  in  8  byte to send.
- tx_last  in  1  commit the packet after this byte.
- tx_valid  in  1  tx_data, tx_last valid.
- tx_ready  out  1  byte accepted this cycle.
- tx_flush  in  1  single-cycle request to commit the current packet with no data.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- All FX2 outputs are registered.
- FX_DATA is driven only in WR; it is hi-Z in every other state.
- FSM states:
  - IDLE: SLOE=1, SLRD=SLWR=PKTEND=1.
  - RD_ADDR: FIFOADR1=0, SLOE=0.
  - RD: SLRD=0 for one cycle; the byte is sampled into the buffer on that edge.
  - RD_GAP: SLRD=1 while the flag settles.
  - WR_ADDR: FIFOADR1=1.
  - WR: SLWR=0, bus driven.
  - PK_WAIT: one idle cycle.
  - PKTEND: PKTEND=0 for one cycle.
- Arbitration, evaluated in IDLE:
  1. Pending commit.
  2. tx_valid with FX_FULL=1.
  3. RX when FX_EMPTY=1 and the buffer has at least one free entry.
  4. Otherwise stay in IDLE.
- Transmit path:
  - tx_ready pulses for exactly one cycle in WR; the byte is latched at WR entry.
  - From WR: go to PK_WAIT if tx_last was set, else IDLE.
  - From PK_WAIT: go to PKTEND.
  - From PKTEND: go to IDLE.
- Receive path:
  - RD → RD_GAP.
  - From RD_GAP: go to RD if FX_EMPTY=1, the buffer is not full and no tx_valid is pending; else IDLE.
  - Peak rate is 1 byte per 2 cycles.
- Endpoint switches always pass through RD_ADDR or WR_ADDR, one cycle with no strobes. SLOE is deasserted before FX_DATA is driven.
- The receive buffer is a standard FIFO:
  - Simultaneous push and pop while full is not possible, because reads require a free entry.
  - A simultaneous push and pop at any other fill level keeps the count unchanged.
- If FX_FULL drops while transmit is pending, the FSM stays in IDLE and tx_ready stays low.

## Timing
- Reset values: FX_FIFOADR1=0, SLOE=SLRD=SLWR=PKTEND=1, FX_DATA hi-Z, rx_valid=0, tx_ready=0, busy=0, buffer empty.
- RST mid-transfer aborts at once. A byte already strobed is lost and no PKTEND is issued.
- RX latency: FX_EMPTY rising in IDLE gives SLRD low 2 cycles later. rx_valid rises the cycle after that.
- TX latency: tx_valid in IDLE gives SLWR low 2 cycles later, with tx_ready in the same cycle.
- Commit: PKTEND goes low 2 cycles after the last SLWR.
- tx_flush arriving while a transmit is in progress is latched and serviced after it completes.

## Configuration
- FX2_PORT_ZLP_EN defined: tx_flush from IDLE goes WR_ADDR → PK_WAIT → PKTEND, emitting a zero-length or short-packet commit.
- FX2_PORT_ZLP_EN undefined: tx_flush is ignored, and only tx_last commits packets.

## Structure
- Package fx2_port_pkg holds:
  - the FSM state enum;
  - endpoint constants EP2_OUT=1'b0 and EP6_IN=1'b1;
  - strobe idle value constants.
- Sub-module fx2_rx_fifo holds the RX_DEPTH-entry synchronous buffer, with push/pop/full/empty/count.

## Test plan
- Reset, then FX_EMPTY=1 with bytes 0x9F, 0x00: two SLRD pulses 2 cycles apart, then rx_data 0x9F then 0x00 delivered with rx_ready=1.
- rx_ready held 0 with FX_EMPTY held 1: exactly 4 SLRD pulses, then SLRD stays high until a pop.
- tx 0xA5 with tx_last=1: WR_ADDR, one SLWR with FX_DATA=0xA5, one idle cycle, one PKTEND pulse, FX_DATA hi-Z afterwards.
- tx_valid and FX_EMPTY both asserted in IDLE: transmit is served first, with one FIFOADR turnaround cycle before any read.
- FX_FULL=0 with tx_valid=1 for 10 cycles: no SLWR and tx_ready=0; FX_FULL=1 gives SLWR 2 cycles later.
- With FX2_PORT_ZLP_EN, tx_flush in IDLE: PKTEND pulse with no SLWR. Without the macro: no strobes.

Source files
------------

// File: rtl/fx2_port_pkg.sv
// Shared types and constants for the FX2 slave-FIFO port controller.
package fx2_port_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD,
        ST_RD_GAP,
        ST_WR_ADDR,
        ST_WR,
        ST_PK_WAIT,
        ST_PKTEND
    } state_e;

    localparam logic EP2_OUT = 1'b0;
    localparam logic EP6_IN  = 1'b1;

    // FX2 strobes are active low
    localparam logic STROBE_IDLE   = 1'b1;
    localparam logic STROBE_ACTIVE = 1'b0;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } tx_beat_t;

endpackage

// File: rtl/fx2_rx_fifo.sv
// Synchronous receive buffer: DEPTH entries (power of two), registered flags and count.
module fx2_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/fx2_fifo_port.sv
// FX2 slave-FIFO port: EP2 OUT -> buffered rx stream, tx stream -> EP6 IN with PKTEND commit.
// Define FX2_PORT_ZLP_EN to let tx_flush issue a data-less packet commit.
module fx2_fifo_port
    import fx2_port_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic              FX_IFCLK,
    input  logic              RST,
    output logic              FX_FIFOADR1,
    input  logic              FX_FULL,
    input  logic              FX_EMPTY,
    output logic              FX_SLOE,
    output logic              FX_SLRD,
    output logic              FX_SLWR,
    output logic              FX_PKTEND,
    inout  wire  [BYTE_W-1:0] FX_DATA,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              tx_flush,
    output logic              busy
);

    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

    state_e   state_q, state_d;
    logic     fifoadr_q, fifoadr_d;
    logic     sloe_q, sloe_d;
    logic     slrd_q, slrd_d;
    logic     slwr_q, slwr_d;
    logic     pktend_q, pktend_d;
    logic     tx_ready_q, tx_ready_d;
    logic     busy_q, busy_d;
    logic     data_oe_q, data_oe_d;
    tx_beat_t tx_beat_q, tx_beat_d;

    logic                rx_full, rx_empty, rx_has_free;
    logic [RX_CNT_W-1:0] rx_count;
    logic                commit_req, commit_sel;

    fx2_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (BYTE_W)
    ) u_rx_fifo (
        .clk       (FX_IFCLK),
        .rst       (RST),
        .push      (state_q == ST_RD),
        .push_data (FX_DATA),
        .pop       (rx_valid && rx_ready),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign rx_valid    = !rx_empty;
    assign rx_has_free = (rx_count < RX_CNT_W'(RX_DEPTH));

`ifdef FX2_PORT_ZLP_EN
    logic commit_pend_q, commit_pend_d;

    // A flush is held until the WR_ADDR turnaround that services it.
    always_comb begin
        commit_pend_d = commit_pend_q | tx_flush;
        if (state_q == ST_WR_ADDR && commit_pend_q) begin
            commit_pend_d = tx_flush;
        end
    end

    always_ff @(posedge FX_IFCLK or posedge RST) begin
        if (RST) begin
            commit_pend_q <= 1'b0;
        end else begin
            commit_pend_q <= commit_pend_d;
        end
    end

    assign commit_req = commit_pend_q | tx_flush;
    assign commit_sel = commit_pend_q;
`else
    logic flush_unused;
    assign flush_unused = tx_flush;
    assign commit_req   = 1'b0;
    assign commit_sel   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tx_beat_d = tx_beat_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d = ST_WR_ADDR;
                end else if (tx_valid && FX_FULL) begin
                    state_d = ST_WR_ADDR;
                end else if (FX_EMPTY && rx_has_free) begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: state_d = ST_RD;
            ST_RD:      state_d = ST_RD_GAP;
            ST_RD_GAP: begin
                if (FX_EMPTY && !rx_full && !tx_valid && !commit_req) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                if (commit_sel) begin
                    state_d = ST_PK_WAIT;
                end else begin
                    state_d   = ST_WR;
                    tx_beat_d = '{last: tx_last, data: tx_data};
                end
            end
            ST_WR:      state_d = tx_beat_q.last ? ST_PK_WAIT : ST_IDLE;
            ST_PK_WAIT: state_d = ST_PKTEND;
            ST_PKTEND:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Pin values are decoded from the next state so they line up with the state register.
        fifoadr_d  = fifoadr_q;
        sloe_d     = STROBE_IDLE;
        slrd_d     = STROBE_IDLE;
        slwr_d     = STROBE_IDLE;
        pktend_d   = STROBE_IDLE;
        tx_ready_d = 1'b0;
        data_oe_d  = 1'b0;
        case (state_d)
            ST_RD_ADDR, ST_RD_GAP: begin
                fifoadr_d = EP2_OUT;
                sloe_d    = STROBE_ACTIVE;
            end
            ST_RD: begin
                fifoadr_d = EP2_OUT;
                sloe_d    = STROBE_ACTIVE;
                slrd_d    = STROBE_ACTIVE;
            end
            ST_WR_ADDR, ST_PK_WAIT: begin
                fifoadr_d = EP6_IN;
            end
            ST_WR: begin
                fifoadr_d  = EP6_IN;
                slwr_d     = STROBE_ACTIVE;
                tx_ready_d = 1'b1;
                data_oe_d  = 1'b1;
            end
            ST_PKTEND: begin
                fifoadr_d = EP6_IN;
                pktend_d  = STROBE_ACTIVE;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge FX_IFCLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            fifoadr_q  <= EP2_OUT;
            sloe_q     <= STROBE_IDLE;
            slrd_q     <= STROBE_IDLE;
            slwr_q     <= STROBE_IDLE;
            pktend_q   <= STROBE_IDLE;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_beat_q  <= '0;
        end else begin
            state_q    <= state_d;
            fifoadr_q  <= fifoadr_d;
            sloe_q     <= sloe_d;
            slrd_q     <= slrd_d;
            slwr_q     <= slwr_d;
            pktend_q   <= pktend_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            data_oe_q  <= data_oe_d;
            tx_beat_q  <= tx_beat_d;
        end
    end

    assign FX_FIFOADR1 = fifoadr_q;
    assign FX_SLOE     = sloe_q;
    assign FX_SLRD     = slrd_q;
    assign FX_SLWR     = slwr_q;
    assign FX_PKTEND   = pktend_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign FX_DATA     = data_oe_q ? tx_beat_q.data : {BYTE_W{1'bz}};

endmodule

// File: tb/tb_fx2_fifo_port.sv
// Scoreboard bench for fx2_fifo_port with a cycle-stamped FX2 FIFO model.
module tb_fx2_fifo_port;

    localparam int EV_RD = 0;
    localparam int EV_WR = 1;
    localparam int EV_PK = 2;
    localparam int EV_RX = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       fx_full;
    logic       fx_empty;
    logic       fifoadr1, sloe, slrd, slwr, pktend;
    wire  [7:0] fx_data;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_last, tx_valid, tx_ready, tx_flush, busy;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int t0;

    ev_t        exp_fx[$];
    ev_t        exp_rx[$];
    logic [7:0] out_q[$];
    logic [7:0] head;
    logic       rd_pend;

    fx2_fifo_port #(.RX_DEPTH(4)) dut (
        .FX_IFCLK    (clk),
        .RST         (rst),
        .FX_FIFOADR1 (fifoadr1),
        .FX_FULL     (fx_full),
        .FX_EMPTY    (fx_empty),
        .FX_SLOE     (sloe),
        .FX_SLRD     (slrd),
        .FX_SLWR     (slwr),
        .FX_PKTEND   (pktend),
        .FX_DATA     (fx_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_flush    (tx_flush),
        .busy        (busy)
    );

    // EP2 OUT side of the FX2: drives the head byte while SLOE is low on EP2.
    assign fx_data = (!sloe && !fifoadr1) ? head : 8'hzz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // A byte strobed with SLRD low leaves the FIFO after that edge; flag follows.
    initial begin
        fx_empty = 1'b0;
        head     = 8'h00;
        rd_pend  = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_pend && out_q.size() > 0) void'(out_q.pop_front());
            rd_pend  = !slrd && !rst;
            fx_empty = (out_q.size() != 0);
            head     = (out_q.size() != 0) ? out_q[0] : 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.cyc  = c;
        if (kind == EV_RX) exp_rx.push_back(e);
        else exp_fx.push_back(e);
    endtask

    task automatic got_fx(input int kind, input logic [7:0] d);
        ev_t e;
        if (exp_fx.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe @cyc %0d: got kind %0d, want none", cyc, kind);
        end else begin
            e = exp_fx.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_cycle", cyc, e.cyc);
            if (kind == EV_WR) chk("wr_data", {24'd0, d}, {24'd0, e.data});
        end
    endtask

    task automatic got_rx(input logic [7:0] d);
        ev_t e;
        if (exp_rx.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rx @cyc %0d: got %0h, want none", cyc, d);
        end else begin
            e = exp_rx.pop_front();
            chk("rx_data", {24'd0, d}, {24'd0, e.data});
            chk("rx_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every visible transaction is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!slrd) got_fx(EV_RD, 8'h00);
        if (!slwr) begin
            got_fx(EV_WR, fx_data);
            chk("sloe_off_during_wr", {31'd0, sloe}, 32'd1);
        end
        if (!pktend) got_fx(EV_PK, 8'h00);
        if (rx_valid && rx_ready) got_rx(rx_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d, input logic last);
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        fx_full  = 1'b1;
        rx_ready = 1'b1;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        tx_valid = 1'b0;
        tx_flush = 1'b0;
        tick(3);
        chk("rst_fifoadr1", {31'd0, fifoadr1}, 32'd0);
        chk("rst_sloe", {31'd0, sloe}, 32'd1);
        chk("rst_slrd", {31'd0, slrd}, 32'd1);
        chk("rst_slwr", {31'd0, slwr}, 32'd1);
        chk("rst_pktend", {31'd0, pktend}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus_released", {31'd0, dut.data_oe_q}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Two bytes read back-to-back and streamed out.
        t0 = cyc;
        out_q.push_back(8'h9F);
        out_q.push_back(8'h00);
        expect_ev(EV_RD, 8'h00, t0 + 2);
        expect_ev(EV_RD, 8'h00, t0 + 4);
        expect_ev(EV_RX, 8'h9F, t0 + 3);
        expect_ev(EV_RX, 8'h00, t0 + 5);
        tick(8);

        // Consumer stalled: buffer fills after four reads, then drains.
        t0 = cyc;
        rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) out_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) expect_ev(EV_RD, 8'h00, t0 + 2 + 2 * i);
        tick(14);
        chk("full_idle_busy", {31'd0, busy}, 32'd0);
        t0 = cyc;
        rx_ready = 1'b1;
        expect_ev(EV_RD, 8'h00, t0 + 3);
        expect_ev(EV_RD, 8'h00, t0 + 5);
        for (int i = 0; i < 5; i++) expect_ev(EV_RX, 8'h10 + 8'(i), t0 + i);
        expect_ev(EV_RX, 8'h15, t0 + 6);
        tick(10);

        // Single byte with commit.
        t0 = cyc;
        start_tx(8'hA5, 1'b1);
        expect_ev(EV_WR, 8'hA5, t0 + 2);
        expect_ev(EV_PK, 8'h00, t0 + 4);
        tick(1);
        chk("wr_addr_fifoadr1", {31'd0, fifoadr1}, 32'd1);
        chk("wr_addr_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("wr_addr_busy", {31'd0, busy}, 32'd1);
        tick(1);
        chk("wr_tx_ready", {31'd0, tx_ready}, 32'd1);
        tick(1);
        tx_valid = 1'b0;
        chk("tx_ready_one_cycle", {31'd0, tx_ready}, 32'd0);
        tick(2);
        chk("post_pkt_bus_released", {31'd0, dut.data_oe_q}, 32'd0);
        chk("post_pkt_pktend", {31'd0, pktend}, 32'd1);
        tick(2);

        // Transmit wins over receive; one turnaround cycle before the read.
        t0 = cyc;
        out_q.push_back(8'h33);
        start_tx(8'h5A, 1'b0);
        expect_ev(EV_WR, 8'h5A, t0 + 2);
        expect_ev(EV_RD, 8'h00, t0 + 5);
        expect_ev(EV_RX, 8'h33, t0 + 6);
        tick(3);
        tx_valid = 1'b0;
        tick(1);
        chk("turnaround_fifoadr1", {31'd0, fifoadr1}, 32'd0);
        chk("turnaround_slrd", {31'd0, slrd}, 32'd1);
        chk("turnaround_sloe", {31'd0, sloe}, 32'd0);
        tick(6);

        // FX_FULL low stalls transmit.
        t0 = cyc;
        fx_full = 1'b0;
        start_tx(8'hC3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("stall_tx_ready", {31'd0, tx_ready}, 32'd0);
        end
        fx_full = 1'b1;
        expect_ev(EV_WR, 8'hC3, t0 + 12);
        expect_ev(EV_PK, 8'h00, t0 + 14);
        tick(2);
        chk("unstall_tx_ready", {31'd0, tx_ready}, 32'd1);
        tick(1);
        tx_valid = 1'b0;
        tick(4);

        // Flush from IDLE.
        t0 = cyc;
        tx_flush = 1'b1;
`ifdef FX2_PORT_ZLP_EN
        expect_ev(EV_PK, 8'h00, t0 + 3);
`endif
        tick(1);
        tx_flush = 1'b0;
`ifdef FX2_PORT_ZLP_EN
        chk("flush_busy", {31'd0, busy}, 32'd1);
`else
        chk("flush_busy", {31'd0, busy}, 32'd0);
`endif
        tick(5);

        // Flush during a transmit is serviced after it.
        t0 = cyc;
        start_tx(8'h77, 1'b0);
        expect_ev(EV_WR, 8'h77, t0 + 2);
`ifdef FX2_PORT_ZLP_EN
        expect_ev(EV_PK, 8'h00, t0 + 6);
`endif
        tick(1);
        tx_flush = 1'b1;
        tick(1);
        tx_flush = 1'b0;
        tick(1);
        tx_valid = 1'b0;
        tick(6);

        // Park one byte in the buffer, then reset in the middle of a packet.
        t0 = cyc;
        rx_ready = 1'b0;
        out_q.push_back(8'h44);
        expect_ev(EV_RD, 8'h00, t0 + 2);
        tick(6);
        chk("parked_rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("parked_rx_data", {24'd0, rx_data}, 32'h44);
        t0 = cyc;
        start_tx(8'hE1, 1'b1);
        expect_ev(EV_WR, 8'hE1, t0 + 2);
        tick(3);
        tx_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_pktend", {31'd0, pktend}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_fifoadr1", {31'd0, fifoadr1}, 32'd0);
        chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("abort_bus_released", {31'd0, dut.data_oe_q}, 32'd0);
        tick(2);
        rst = 1'b0;
        rx_ready = 1'b1;
        tick(6);

        chk("strobe_queue_drained", exp_fx.size(), 32'd0);
        chk("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
